// File: rtl/pit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pit_pkg
// Description : Shared constants for the multi-channel interval timer:
//               write field selects and CTRL bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package pit_pkg;

    // Field select encodings on wr_sel (3 is reserved and ignored)
    localparam logic [1:0] SEL_RELOAD = 2'd0;
    localparam logic [1:0] SEL_PRESC  = 2'd1;
    localparam logic [1:0] SEL_CTRL   = 2'd2;

    // CTRL register bit positions
    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_W        = 3;

endpackage : pit_pkg
`default_nettype wire

// File: rtl/pit_channel.sv
`default_nettype none
// ============================================================================
// Module      : pit_channel
// Description : One down-counting timer channel with reload, prescaler,
//               one-shot/periodic mode and a sticky interrupt flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pit_channel
    import pit_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_reload_i,
    input  logic             wr_presc_i,
    input  logic             wr_ctrl_i,
    input  logic [CNT_W-1:0] wr_data_i,
    input  logic             irq_ack_i,
    output logic [CNT_W-1:0] count_o,
    output logic             running_o,
    output logic             pending_o
);

    logic [CNT_W-1:0]   reload_q,    reload_d;
    logic [PRESC_W-1:0] presc_q,     presc_d;
    logic [CTRL_W-1:0]  ctrl_q,      ctrl_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic               pending_q,   pending_d;

    logic w_tick;
    logic w_expire;

    // A tick happens when the prescaler has reached its terminal value;
    // a tick on a zero count is an expiry (the counter never wraps).
    assign w_tick   = ctrl_q[CTRL_EN] && (presc_cnt_q == presc_q);
    assign w_expire = w_tick && (count_q == '0);

    // Next-state: counting first, then a CTRL write overrides reload/stop,
    // while an expiry in the same cycle still raises pending.
    always_comb begin
        reload_d    = wr_reload_i ? wr_data_i : reload_q;
        presc_d     = wr_presc_i ? wr_data_i[PRESC_W-1:0] : presc_q;
        ctrl_d      = ctrl_q;
        count_d     = count_q;
        presc_cnt_d = presc_cnt_q;
        pending_d   = pending_q;

        if (ctrl_q[CTRL_EN]) begin
            presc_cnt_d = w_tick ? '0 : presc_cnt_q + PRESC_W'(1);
            if (w_tick) begin
                if (!w_expire) begin
                    count_d = count_q - CNT_W'(1);
                end else if (ctrl_q[CTRL_PERIODIC]) begin
                    // Uses the reload value held before any same-cycle write
                    count_d = reload_q;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                end
            end
        end

        if (wr_ctrl_i) begin
            ctrl_d = wr_data_i[CTRL_W-1:0];
            if (wr_data_i[CTRL_EN]) begin
                count_d     = reload_q;
                presc_cnt_d = '0;
            end else begin
                count_d     = count_q;
                presc_cnt_d = presc_cnt_q;
            end
        end

        if (w_expire && ctrl_q[CTRL_IRQ_EN]) begin
            pending_d = 1'b1;
        end else if (irq_ack_i) begin
            pending_d = 1'b0;
        end
    end

    // Channel state registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload_q    <= '0;
            presc_q     <= '0;
            ctrl_q      <= '0;
            count_q     <= '0;
            presc_cnt_q <= '0;
            pending_q   <= 1'b0;
        end else begin
            reload_q    <= reload_d;
            presc_q     <= presc_d;
            ctrl_q      <= ctrl_d;
            count_q     <= count_d;
            presc_cnt_q <= presc_cnt_d;
            pending_q   <= pending_d;
        end
    end

    assign count_o   = count_q;
    assign running_o = ctrl_q[CTRL_EN];
    assign pending_o = pending_q;

endmodule : pit_channel
`default_nettype wire

// File: rtl/multi_pit.sv
`default_nettype none
// ============================================================================
// Module      : multi_pit
// Description : NUM_CH independent programmable interval timers behind one
//               write port, with count readback mux and a combined irq.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_pit
    import pit_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int CNT_W   = 16,
    parameter  int PRESC_W = 8,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [1:0]        wr_sel,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic [NUM_CH-1:0] irq_ack,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [CNT_W-1:0]  rd_count,
    output logic [NUM_CH-1:0] running,
    output logic [NUM_CH-1:0] irq_pending,
    output logic              irq
);

    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH-1:0] w_wr_reload;
    logic [NUM_CH-1:0] w_wr_presc;
    logic [NUM_CH-1:0] w_wr_ctrl;
    logic [CNT_W-1:0]  w_count [NUM_CH];
    logic              irq_q;

    // Channel indices beyond NUM_CH-1 match no instance, so such writes
    // fall away; wr_sel=3 matches none of the field strobes.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_hit[i]       = wr_en && (wr_ch == CH_W'(i));
        assign w_wr_reload[i] = w_hit[i] && (wr_sel == SEL_RELOAD);
        assign w_wr_presc[i]  = w_hit[i] && (wr_sel == SEL_PRESC);
        assign w_wr_ctrl[i]   = w_hit[i] && (wr_sel == SEL_CTRL);

        pit_channel #(
            .CNT_W   (CNT_W),
            .PRESC_W (PRESC_W)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .wr_reload_i (w_wr_reload[i]),
            .wr_presc_i  (w_wr_presc[i]),
            .wr_ctrl_i   (w_wr_ctrl[i]),
            .wr_data_i   (wr_data),
            .irq_ack_i   (irq_ack[i]),
            .count_o     (w_count[i]),
            .running_o   (running[i]),
            .pending_o   (irq_pending[i])
        );
    end

    // Count readback mux; an out-of-range channel reads as zero
    always_comb begin
        rd_count = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_count = w_count[i];
            end
        end
    end

    // Combined interrupt, registered one cycle behind the pending flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |irq_pending;
        end
    end

    assign irq = irq_q;

endmodule : multi_pit
`default_nettype wire

// File: tb/tb_multi_pit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_pit
// Description : Directed self-checking bench for multi_pit (4 channels).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_pit;

    localparam logic [1:0] S_RELOAD = 2'd0;
    localparam logic [1:0] S_PRESC  = 2'd1;
    localparam logic [1:0] S_CTRL   = 2'd2;
    localparam logic [1:0] S_RSVD   = 2'd3;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [1:0]  wr_sel;
    logic [15:0] wr_data;
    logic [3:0]  irq_ack;
    logic [1:0]  rd_ch;
    logic [15:0] rd_count;
    logic [3:0]  running;
    logic [3:0]  irq_pending;
    logic        irq;

    int errors = 0;
    int checks = 0;

    multi_pit #(
        .NUM_CH  (4),
        .CNT_W   (16),
        .PRESC_W (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .irq_ack     (irq_ack),
        .rd_ch       (rd_ch),
        .rd_count    (rd_count),
        .running     (running),
        .irq_pending (irq_pending),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        do_wr;
        logic [1:0]  sel;
        logic [1:0]  ch;
        logic [15:0] data;
        logic [3:0]  ack;
        int          n;
        logic [15:0] exp_cnt;
        logic [3:0]  exp_run;
        logic [3:0]  exp_pend;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] ch, input logic [1:0] sel, input logic [15:0] data);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_sel  = sel;
        wr_data = data;
        step(1);
        wr_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int wt [4];
        int rl [4];
        logic [3:0] ep, er;

        reset = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_sel = '0; wr_data = '0;
        irq_ack = '0; rd_ch = '0;

        // ---------------- reset values ----------------
        #1 reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        chk("rst_running", running, 4'h0);
        chk("rst_pending", irq_pending, 4'h0);
        chk("rst_irq", irq, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rd_ch = 2'(i);
            #1;
            chk($sformatf("rst_count%0d", i), rd_count, 16'd0);
        end
        rd_ch = 2'd0;

        // ---------------- one-shot on ch0 (table) ----------------
        tbl[0] = '{1'b1, S_RSVD,   2'd0, 16'h0007, 4'h0, 1, 16'd0, 4'h0, 4'h0, 1'b0};
        tbl[1] = '{1'b1, S_RELOAD, 2'd0, 16'd5,    4'h0, 0, 16'd0, 4'h0, 4'h0, 1'b0};
        tbl[2] = '{1'b1, S_PRESC,  2'd0, 16'd0,    4'h0, 0, 16'd0, 4'h0, 4'h0, 1'b0};
        tbl[3] = '{1'b1, S_CTRL,   2'd0, 16'h0005, 4'h0, 0, 16'd5, 4'h1, 4'h0, 1'b0};
        tbl[4] = '{1'b0, S_RELOAD, 2'd0, 16'd0,    4'h0, 4, 16'd1, 4'h1, 4'h0, 1'b0};
        tbl[5] = '{1'b0, S_RELOAD, 2'd0, 16'd0,    4'h0, 1, 16'd0, 4'h1, 4'h0, 1'b0};
        tbl[6] = '{1'b0, S_RELOAD, 2'd0, 16'd0,    4'h0, 1, 16'd0, 4'h0, 4'h1, 1'b0};
        tbl[7] = '{1'b0, S_RELOAD, 2'd0, 16'd0,    4'h0, 1, 16'd0, 4'h0, 4'h1, 1'b1};
        tbl[8] = '{1'b0, S_RELOAD, 2'd0, 16'd0,    4'h1, 1, 16'd0, 4'h0, 4'h0, 1'b1};
        tbl[9] = '{1'b0, S_RELOAD, 2'd0, 16'd0,    4'h0, 1, 16'd0, 4'h0, 4'h0, 1'b0};

        for (int k = 0; k < 10; k++) begin
            irq_ack = tbl[k].ack;
            if (tbl[k].do_wr) wr(tbl[k].ch, tbl[k].sel, tbl[k].data);
            step(tbl[k].n);
            irq_ack = 4'h0;
            chk($sformatf("os%0d_count", k), rd_count, tbl[k].exp_cnt);
            chk($sformatf("os%0d_running", k), running, tbl[k].exp_run);
            chk($sformatf("os%0d_pending", k), irq_pending, tbl[k].exp_pend);
            chk($sformatf("os%0d_irq", k), irq, tbl[k].exp_irq);
        end

        // ---------------- periodic with prescaler on ch1 ----------------
        rd_ch = 2'd1;
        wr(2'd1, S_RELOAD, 16'd3);
        wr(2'd1, S_PRESC, 16'd2);
        wr(2'd1, S_CTRL, 16'h0007);
        t = 0;
        for (int p = 0; p < 3; p++) begin
            step(12 * (p + 1) - 1 - t);
            t = 12 * (p + 1) - 1;
            chk($sformatf("per%0d_before", p), irq_pending[1], 1'b0);
            step(1); t++;
            chk($sformatf("per%0d_set", p), irq_pending[1], 1'b1);
            chk($sformatf("per%0d_reload", p), rd_count, 16'd3);
            irq_ack = 4'b0010;
            step(1); t++;
            irq_ack = 4'h0;
            chk($sformatf("per%0d_ack", p), irq_pending[1], 1'b0);
        end
        wr(2'd1, S_CTRL, 16'h0000);

        // ---------------- ack/set collision on ch2 ----------------
        irq_ack = 4'b0100;
        wr(2'd2, S_RELOAD, 16'd0);
        wr(2'd2, S_PRESC, 16'd0);
        wr(2'd2, S_CTRL, 16'h0007);
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk($sformatf("coll%0d_pending", k), irq_pending[2], 1'b1);
        end
        wr(2'd2, S_CTRL, 16'h0000);
        chk("coll_stop_pending", irq_pending[2], 1'b1);
        chk("coll_stop_running", running[2], 1'b0);
        step(1);
        chk("coll_ack_clear", irq_pending[2], 1'b0);
        irq_ack = 4'h0;

        // ---------------- live reload and restart on ch3 ----------------
        rd_ch = 2'd3;
        wr(2'd3, S_RELOAD, 16'd10);
        wr(2'd3, S_CTRL, 16'h0007);
        chk("live_start", rd_count, 16'd10);
        step(2);
        wr(2'd3, S_RELOAD, 16'd2);
        chk("live_untouched", rd_count, 16'd7);
        step(7);
        chk("live_t10_pend", irq_pending[3], 1'b0);
        chk("live_t10_cnt", rd_count, 16'd0);
        step(1);
        chk("live_t11_pend", irq_pending[3], 1'b1);
        chk("live_t11_cnt", rd_count, 16'd2);
        irq_ack = 4'b1000;
        step(1);
        irq_ack = 4'h0;
        chk("live_t12_ack", irq_pending[3], 1'b0);
        step(1);
        chk("live_t13_pend", irq_pending[3], 1'b0);
        step(1);
        chk("live_t14_pend", irq_pending[3], 1'b1);
        chk("live_t14_cnt", rd_count, 16'd2);
        step(1);
        wr(2'd3, S_CTRL, 16'h0007);
        chk("restart_cnt", rd_count, 16'd2);
        step(1);
        chk("restart_next", rd_count, 16'd1);

        // ---------------- independence ----------------
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        chk("ind_rst_running", running, 4'h0);
        chk("ind_rst_pending", irq_pending, 4'h0);
        rl[0] = 1; rl[1] = 4; rl[2] = 7; rl[3] = 9;
        wt[0] = 5; wt[1] = 6; wt[2] = 7; wt[3] = 8;
        for (int i = 0; i < 4; i++) wr(2'(i), S_RELOAD, 16'(rl[i]));
        for (int i = 0; i < 4; i++) wr(2'(i), S_CTRL, 16'h0005);
        for (t = 8; t <= 20; t++) begin
            for (int i = 0; i < 4; i++) begin
                ep[i] = (t >= wt[i] + rl[i] + 1);
                er[i] = (t >= wt[i]) && (t < wt[i] + rl[i] + 1);
            end
            chk($sformatf("ind_t%0d_pending", t), irq_pending, ep);
            chk($sformatf("ind_t%0d_running", t), running, er);
            step(1);
        end

        // ---------------- async reset mid-count ----------------
        rd_ch = 2'd1;
        wr(2'd1, S_RELOAD, 16'd100);
        wr(2'd1, S_CTRL, 16'h0007);
        step(3);
        chk("arst_pre_count", rd_count, 16'd97);
        chk("arst_pre_irq", irq, 1'b1);
        #3 reset = 1'b1;
        #1;
        chk("arst_running", running, 4'h0);
        chk("arst_pending", irq_pending, 4'h0);
        chk("arst_irq", irq, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rd_ch = 2'(i);
            #0.1;
            chk($sformatf("arst_count%0d", i), rd_count, 16'd0);
        end
        #1 reset = 1'b0;
        step(2);
        chk("arst_post_running", running, 4'h0);
        chk("arst_post_pending", irq_pending, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_multi_pit
`default_nettype wire

// File: doc/multi_pit.md
Name: multi_pit

Overview:
- Multi-channel programmable interval timer, the parametrised successor of the single-channel timer.
- NUM_CH independent down-counting channels. Each channel has:
  - its own reload value and prescaler;
  - one-shot or periodic mode;
  - a sticky, acknowledgeable interrupt.
- Sits beside the JTAG/config register block. A single write port programs the channels. A combined irq line goes to the host.

Parameters:
- NUM_CH, 4: number of timer channels (1..16).
- CNT_W, 16: counter and reload width in bits.
- PRESC_W, 8: prescaler width in bits.
- CH_W, $clog2(NUM_CH) with minimum 1: channel index width. Derived; not overridden.

Ports:
- clk  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe, one cycle per write.
- wr_ch  in  CH_W  target channel of write.
- wr_sel  in  2  field select: 0=RELOAD, 1=PRESC, 2=CTRL, 3=reserved.
- wr_data  in  CNT_W  write data. PRESC uses [PRESC_W-1:0]. CTRL uses [2:0].
- irq_ack  in  NUM_CH  per-channel pending clear, level-sampled.
- rd_ch  in  CH_W  channel selected for count readback.
- rd_count  out  CNT_W  current count of rd_ch, combinational mux.
- running  out  NUM_CH  channel enabled and counting.
- irq_pending  out  NUM_CH  sticky per-channel interrupt flags.
- irq  out  1  registered OR of irq_pending.

Behaviour:
- Reset (async assert, sync release): every register is 0.
  - This covers reload, presc, count, presc_cnt, ctrl, pending and irq.
  - All outputs are therefore 0, and rd_count reads 0.
- CTRL bits:
  - [0] EN: run.
  - [1] PERIODIC.
  - [2] IRQ_EN: allow pending to set.
- Writes:
  - A write with wr_ch >= NUM_CH, or wr_sel=3, is ignored.
  - RELOAD write: updates reload only. The current count is untouched, so the new value is used at the next reload or enable.
  - PRESC write: updates presc only. presc_cnt is not reset.
  - CTRL write with EN=1: loads count<=reload and presc_cnt<=0 at the write edge. This also applies while the channel is already running, which restarts it.
  - CTRL write with EN=0: stops the channel at once. count is held and pending is unchanged.
- Counting, per channel, each edge while EN=1:
  - If presc_cnt != presc: presc_cnt+1 and no tick.
  - Else presc_cnt<=0 and tick.
  - On a tick with count != 0: count-1.
  - On a tick with count == 0 (expiry):
    - If IRQ_EN, pending<=1.
    - If PERIODIC, count<=reload.
    - Else EN<=0, count stays 0, and running drops on the same edge.
- Period is (reload+1)*(presc+1) cycles.
  - reload=0 with presc=0 in periodic mode gives expiry every cycle.
  - With presc=0, pending is visible reload+1 cycles after the enabling write edge.
- Pending:
  - Set wins over irq_ack in the same cycle.
  - Otherwise, irq_ack[i]=1 clears pending[i] on the next edge.
  - Ack on a non-pending channel has no effect.
- irq is registered from the pending vector: 1 cycle after pending.
- A write and an expiry on the same channel in the same cycle:
  - A CTRL write wins over the expiry reload and stop.
  - A CTRL write still does not suppress a pending set from that expiry.
  - A RELOAD write in the expiry cycle is not used by that reload; the old reload value is used.
- Wrap-around: counting down never underflows. count==0 always means expiry on the next tick.
- Reset mid-count: immediate return to all-zero state. No pending is retained.

Decomposition:
- Shared package pit_pkg contains:
  - SEL_RELOAD=0, SEL_PRESC=1, SEL_CTRL=2.
  - CTRL_EN=0, CTRL_PERIODIC=1, CTRL_IRQ_EN=2.
- One sub-module, pit_channel, parametrised by CNT_W and PRESC_W. It holds:
  - the reload, presc, ctrl, count and presc_cnt registers;
  - the pending register.
- multi_pit contains:
  - the write decode (one-hot per channel);
  - a generate loop of NUM_CH pit_channel instances;
  - the rd_count mux and the irq register.

Test Plan:
- Reset values: after reset → all outputs 0, and rd_count=0 for every rd_ch.
- One-shot: ch0 RELOAD=5, PRESC=0, CTRL=0b101 → irq_pending[0] rises 6 cycles after the CTRL write, irq 1 cycle later, and running[0] falls on the same edge as pending. irq_ack[0] clears pending on the next edge.
- Periodic with prescaler: ch1 RELOAD=3, PRESC=2, CTRL=0b111 → expiries every 12 cycles. Ack each one, then check three consecutive periods.
- Ack/set collision: ch2 periodic RELOAD=0, PRESC=0 with irq_ack[2] held high → pending stays 1 every cycle (set wins).
- Live reload and restart: ch3 running with RELOAD=10. Write RELOAD=2 mid-count → the current period still completes at 11 cycles, the next is 3. Write CTRL EN=1 mid-count → count reloads to 2 at once.
- Independence and async reset: all 4 channels run different reloads (1, 4, 7, 9) and the pending timing is checked per channel. An async reset pulse mid-count → all state 0 with no clock edge needed. Writes to wr_sel=3 are ignored.
